fb_swap_ctrl: RTL and testbench

Double-buffer ownership controller for the DDR framebuffer path. HPS software fills the back buffer and commits it over a small Avalon-MM slave. The controller holds the commit pending and raises fb_full until the scanout engine's next vsync, then swaps front/back, counts frames, and presents the new front base address to the scanout DMA.

---
 rtl/fb_swap_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fb_swap_ctrl
// Purpose  : Double-buffer ownership controller. A software commit is held
//            pending until the next vsync, then front/back swap and the frame
//            counter advances. Define FB_SWAP_IRQ_EN to build the swap irq.
// Revision : 1.0 - initial release
// ============================================================================
module fb_swap_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE0_RST = ADDR_W'(32'h3000_0000),
    parameter logic [ADDR_W-1:0] BASE1_RST = ADDR_W'(32'h3040_0000),
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              vsync,
    output logic              fb_full,
    output logic              front_idx,
    output logic [ADDR_W-1:0] front_base,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_enable;
    logic               r_fb_full;
    logic               r_ovr;
    logic               r_front_idx;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [ADDR_W-1:0]  r_base0;
    logic [ADDR_W-1:0]  r_base1;
    logic [ADDR_W-1:0]  r_front_base;

    logic               w_wr;
    logic               w_ctrl_wr;
    logic               w_enter_pend;
    logic               w_disable;
    logic               w_swap;
    logic               w_ovr_set;

    assign w_wr      = chipselect & ~write_n;
    assign w_ctrl_wr = w_wr && (address == 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_pend = 1'b0;
        w_disable    = 1'b0;
        w_swap       = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The ENABLE bit written alongside COMMIT is the one that counts.
                if (w_ctrl_wr && writedata[0] && writedata[1]) begin
                    w_state_nxt  = ST_PENDING;
                    w_enter_pend = 1'b1;
                end
            end
            ST_PENDING: begin
                if (w_ctrl_wr && !writedata[1]) begin
                    w_state_nxt = ST_IDLE;
                    w_disable   = 1'b1;
                end else begin
                    if (vsync) begin
                        w_state_nxt = ST_SWAP;
                    end
                    if (w_ctrl_wr && writedata[0]) begin
                        w_ovr_set = 1'b1;
                    end
                end
            end
            ST_SWAP: begin
                w_state_nxt = ST_IDLE;
                w_swap      = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable     <= 1'b0;
            r_fb_full    <= 1'b0;
            r_ovr        <= 1'b0;
            r_front_idx  <= 1'b0;
            r_frame_cnt  <= '0;
            r_base0      <= BASE0_RST;
            r_base1      <= BASE1_RST;
            r_front_base <= BASE0_RST;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= writedata[1];
            end
            if (w_enter_pend) begin
                r_fb_full <= 1'b1;
            end else if (w_swap || w_disable) begin
                r_fb_full <= 1'b0;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (w_ctrl_wr && writedata[2]) begin
                r_ovr <= 1'b0;
            end
            if (w_swap) begin
                r_front_idx <= ~r_front_idx;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (w_wr && (address == 2'd1)) begin
                r_base0 <= writedata[ADDR_W-1:0];
            end
            if (w_wr && (address == 2'd2)) begin
                r_base1 <= writedata[ADDR_W-1:0];
            end
            // Registered lookup: follows an index toggle or base write one cycle later.
            r_front_base <= r_front_idx ? r_base1 : r_base0;
        end
    end

`ifdef FB_SWAP_IRQ_EN
    logic r_irq;
    logic w_cnt_wr;

    assign w_cnt_wr = w_wr && (address == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (w_swap) begin
            r_irq <= 1'b1;
        end else if (w_cnt_wr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {27'b0, r_ovr, r_front_idx, (r_state == ST_PENDING),
                                 r_fb_full, r_enable};
            2'd1:    readdata = 32'(r_base0);
            2'd2:    readdata = 32'(r_base1);
            default: readdata = 32'(r_frame_cnt);
        endcase
    end

    assign fb_full    = r_fb_full;
    assign front_idx  = r_front_idx;
    assign front_base = r_front_base;

endmodule
`default_nettype wire

// File: tb/tb_fb_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_swap_ctrl
// Purpose  : Directed scoreboard bench for fb_swap_ctrl (frame counter 4 bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_swap_ctrl;

    localparam int C_ADDR_W = 32;
    localparam int C_CNT_W  = 4;
`ifdef FB_SWAP_IRQ_EN
    localparam logic C_IRQ_EXP = 1'b1;
`else
    localparam logic C_IRQ_EXP = 1'b0;
`endif

    localparam int SEL_RD   = 0;
    localparam int SEL_FULL = 1;
    localparam int SEL_IDX  = 2;
    localparam int SEL_BASE = 3;
    localparam int SEL_IRQ  = 4;

    logic                clk;
    logic                reset_n;
    logic [1:0]          address;
    logic                chipselect;
    logic                write_n;
    logic [31:0]         writedata;
    logic [31:0]         readdata;
    logic                vsync;
    logic                fb_full;
    logic                front_idx;
    logic [C_ADDR_W-1:0] front_base;
    logic                irq;

    fb_swap_ctrl #(
        .ADDR_W    (C_ADDR_W),
        .BASE0_RST (32'h3000_0000),
        .BASE1_RST (32'h3040_0000),
        .CNT_W     (C_CNT_W)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .vsync      (vsync),
        .fb_full    (fb_full),
        .front_idx  (front_idx),
        .front_base (front_base),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   mon_cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: each falling edge, compare every expectation due this cycle.
    initial begin
        chk_t        it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            mon_cyc++;
            while (q.size() > 0 && q[0].cyc <= mon_cyc) begin
                it = q.pop_front();
                case (it.sel)
                    SEL_RD:   act = readdata;
                    SEL_FULL: act = {31'b0, fb_full};
                    SEL_IDX:  act = {31'b0, front_idx};
                    SEL_BASE: act = front_base;
                    default:  act = {31'b0, irq};
                endcase
                n_checks++;
                if (act !== it.exp) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             it.name, act, it.exp, mon_cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int sel, input logic [31:0] exp);
        chk_t it;
        it.name = name;
        it.cyc  = mon_cyc + 1;
        it.sel  = sel;
        it.exp  = exp;
        q.push_back(it);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        chk(name, SEL_RD, exp);
        sync();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        vsync      = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        rd("rst_ctrl", 2'd0, 32'h0);
        rd("rst_base0", 2'd1, 32'h3000_0000);
        rd("rst_base1", 2'd2, 32'h3040_0000);
        rd("rst_cnt", 2'd3, 32'h0);
        chk("rst_front_base", SEL_BASE, 32'h3000_0000);
        chk("rst_full", SEL_FULL, 32'h0);
        chk("rst_irq", SEL_IRQ, 32'h0);
        sync();

        // Basic commit then vsync
        wr(2'd0, 32'h3);
        for (int i = 1; i <= 5; i++) begin
            chk("t2_full_wait", SEL_FULL, 32'h1);
            chk("t2_idx_wait", SEL_IDX, 32'h0);
            tick();
        end
        vsync = 1'b1;
        chk("t2_full_vs", SEL_FULL, 32'h1);
        tick();
        vsync = 1'b0;
        chk("t2_full_swap", SEL_FULL, 32'h1);
        chk("t2_idx_swap", SEL_IDX, 32'h0);
        tick();
        chk("t2_full_done", SEL_FULL, 32'h0);
        chk("t2_idx_done", SEL_IDX, 32'h1);
        chk("t2_base_lag", SEL_BASE, 32'h3000_0000);
        tick();
        chk("t2_base_new", SEL_BASE, 32'h3040_0000);
        chk("t2_irq", SEL_IRQ, {31'b0, C_IRQ_EXP});
        sync();
        rd("t2_cnt", 2'd3, 32'h1);
        rd("t2_stat", 2'd0, 32'h9);

        // Double commit -> overrun, single swap, then OVR_CLR
        wr(2'd0, 32'h3);
        wr(2'd0, 32'h3);
        rd("t3_stat_ovr", 2'd0, 32'h1F);
        vsync_pulse();
        tick();
        vsync_pulse();
        tick();
        chk("t3_idx", SEL_IDX, 32'h0);
        sync();
        rd("t3_cnt", 2'd3, 32'h2);
        wr(2'd0, 32'h6);
        rd("t3_stat_clr", 2'd0, 32'h1);

        // Commit coincident with vsync in IDLE
        vsync = 1'b1;
        wr(2'd0, 32'h3);
        vsync = 1'b0;
        tick();
        chk("t4_idx_hold", SEL_IDX, 32'h0);
        chk("t4_full_hold", SEL_FULL, 32'h1);
        vsync_pulse();
        tick();
        chk("t4_idx_swap", SEL_IDX, 32'h1);
        chk("t4_full_clr", SEL_FULL, 32'h0);
        sync();
        rd("t4_cnt", 2'd3, 32'h3);

        // Commit then disable before vsync
        wr(2'd0, 32'h3);
        chk("t5_full_set", SEL_FULL, 32'h1);
        wr(2'd0, 32'h0);
        chk("t5_full_abort", SEL_FULL, 32'h0);
        sync();
        rd("t5_stat", 2'd0, 32'h8);
        vsync_pulse();
        tick();
        chk("t5_idx_keep", SEL_IDX, 32'h1);
        sync();
        wr(2'd0, 32'h3);
        wr(2'd0, 32'h1);
        rd("t5_stat_dis", 2'd0, 32'h8);

        // OVR_CLR with an overrun commit: set wins
        wr(2'd0, 32'h3);
        wr(2'd0, 32'h3);
        wr(2'd0, 32'h7);
        rd("t5b_ovr_win", 2'd0, 32'h1F);
        wr(2'd0, 32'h6);
        rd("t5b_ovr_clr", 2'd0, 32'h0F);
        wr(2'd0, 32'h0);
        rd("t5b_idle", 2'd0, 32'h8);
        rd("t5b_cnt", 2'd3, 32'h3);

        // irq clear via FRAME_CNT write
        chk("irq_held", SEL_IRQ, {31'b0, C_IRQ_EXP});
        sync();
        wr(2'd3, 32'hFFFF_FFFF);
        chk("irq_clr", SEL_IRQ, 32'h0);
        sync();
        rd("cnt_after_wr", 2'd3, 32'h3);

        // BASE1 write reaches front_base one cycle later
        wr(2'd2, 32'h1234_5670);
        chk("base_lag", SEL_BASE, 32'h3040_0000);
        tick();
        chk("base_follow", SEL_BASE, 32'h1234_5670);
        sync();
        rd("base1_rd", 2'd2, 32'h1234_5670);

        // Asynchronous reset while PENDING
        wr(2'd0, 32'h3);
        chk("t6_full_pend", SEL_FULL, 32'h1);
        sync();
        reset_n = 1'b0;
        chk("t6_full_rst", SEL_FULL, 32'h0);
        chk("t6_idx_rst", SEL_IDX, 32'h0);
        chk("t6_base_rst", SEL_BASE, 32'h3000_0000);
        sync();
        tick();
        reset_n = 1'b1;
        rd("t6_stat_rst", 2'd0, 32'h0);
        rd("t6_base1_rst", 2'd2, 32'h3040_0000);

        // 17 commit/vsync pairs on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            wr(2'd0, 32'h3);
            vsync_pulse();
            tick();
        end
        chk("t6_idx_wrap", SEL_IDX, 32'h1);
        chk("t6_full_wrap", SEL_FULL, 32'h0);
        chk("t6_irq_wrap", SEL_IRQ, {31'b0, C_IRQ_EXP});
        sync();
        rd("t6_cnt_wrap", 2'd3, 32'h1);
        rd("t6_stat_wrap", 2'd0, 32'h9);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            sync();
        end
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
            n_errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
